// File: rtl/apple_riscv_pkg.sv
// Shared constants, bus encodings and small datapath helpers for the Apple RISC-V SoC.
package apple_riscv_pkg;

  localparam int unsigned IMEM_ADDR_WIDTH   = 12;
  localparam int unsigned DMEM_ADDR_WIDTH   = 12;
  localparam logic [31:0] DMEM_BASE         = 32'h0000_0000;
  localparam logic [31:0] DMEM_SIZE         = 32'h0000_1000;

  localparam int unsigned HTRANS_ACTIVE_BIT = 1;
  localparam logic [1:0]  HTRANS_IDLE       = 2'b00;
  localparam logic [1:0]  HTRANS_NONSEQ     = 2'b10;
  localparam logic [2:0]  HSIZE_BYTE        = 3'd0;
  localparam logic [2:0]  HSIZE_HALF        = 3'd1;
  localparam logic [2:0]  HSIZE_WORD        = 3'd2;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OPIMM  = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;

  // Byte lanes touched by an access; store funct3[1:0] shares the HSIZE encoding.
  function automatic logic [3:0] lane_mask(input logic [2:0] size, input logic [1:0] addr);
    logic [3:0] m;
    case (size)
      HSIZE_BYTE: m = 4'b0001 << addr;
      HSIZE_HALF: m = 4'b0011 << {addr[1], 1'b0};
      default:    m = 4'b1111;
    endcase
    return m;
  endfunction

  function automatic logic [31:0] alu(input logic [2:0] f3, input logic alt,
                                      input logic [31:0] a, input logic [31:0] b);
    logic [31:0] r;
    case (f3)
      3'd0:    r = alt ? a - b : a + b;
      3'd1:    r = a << b[4:0];
      3'd2:    r = {31'b0, $signed(a) < $signed(b)};
      3'd3:    r = {31'b0, a < b};
      3'd4:    r = a ^ b;
      3'd5:    r = alt ? 32'($signed(a) >>> b[4:0]) : a >> b[4:0];
      3'd6:    r = a | b;
      default: r = a & b;
    endcase
    return r;
  endfunction

  function automatic logic branch_taken(input logic [2:0] f3, input logic [31:0] a,
                                        input logic [31:0] b);
    logic t;
    case (f3)
      3'd0:    t = (a == b);
      3'd1:    t = (a != b);
      3'd4:    t = ($signed(a) < $signed(b));
      3'd5:    t = ($signed(a) >= $signed(b));
      3'd6:    t = (a < b);
      3'd7:    t = (a >= b);
      default: t = 1'b0;
    endcase
    return t;
  endfunction

endpackage

// File: rtl/ahb_imem_dbg_if.sv
// AHB-Lite address/data phase decode for the instruction-memory debug port.
module ahb_imem_dbg_if
  import apple_riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [15:0]           haddr,
  input  logic                  hsel,
  input  logic                  hready,
  input  logic                  hwrite,
  input  logic [2:0]            hsize,
  input  logic [1:0]            htrans,
  input  logic [31:0]           hwdata,
  output logic                  rd_c,
  output logic [ADDR_WIDTH-3:0] rd_idx_c,
  output logic                  wr_c,
  output logic [ADDR_WIDTH-3:0] wr_idx,
  output logic [3:0]            wr_be,
  output logic [31:0]           wdata_c
);

  logic accept_c, wr_pend, unused_bits;

  assign accept_c    = hsel & hready & htrans[HTRANS_ACTIVE_BIT];
  assign unused_bits = ^{haddr[15:ADDR_WIDTH], htrans[0]};
  assign rd_c        = accept_c & ~hwrite;
  assign rd_idx_c    = haddr[ADDR_WIDTH-1:2];
  assign wdata_c     = hwdata;
  // A write whose data phase coincides with reset is dropped.
  assign wr_c        = wr_pend & ~reset;

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_pend <= 1'b0;
      wr_idx  <= '0;
      wr_be   <= 4'd0;
    end else begin
      wr_pend <= accept_c & hwrite;
      if (accept_c) begin
        wr_idx <= haddr[ADDR_WIDTH-1:2];
        wr_be  <= lane_mask(hsize, haddr[1:0]);
      end
    end
  end

endmodule

// File: rtl/apple_riscv.sv
// Multi-cycle RV32I core: fetch, execute, optional memory and load write-back cycles.
module apple_riscv
  import apple_riscv_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  output logic [31:0] fetch_addr,
  input  logic [31:0] fetch_data,
  output logic [31:0] mem_addr,
  output logic        mem_we,
  output logic [3:0]  mem_be,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {S_FETCH, S_EXEC, S_MEM, S_WB} state_e;

  state_e      state;
  logic [31:0] pc;
  logic [31:0] rf [0:31];
  logic        ld_pending;
  logic [2:0]  ld_f3;
  logic [4:0]  ld_rd;

  logic [31:0] ins, rs1v, rs2v, imm_i, imm_s, imm_b, imm_u, imm_j;
  logic [31:0] alu_r, ld_raw, next_pc, rd_val, store_data;
  logic [4:0]  rd_idx;
  logic        rd_we, alt;

  assign fetch_addr = pc;
  assign ins   = fetch_data;
  assign rs1v  = (ins[19:15] == 5'd0) ? 32'd0 : rf[ins[19:15]];
  assign rs2v  = (ins[24:20] == 5'd0) ? 32'd0 : rf[ins[24:20]];
  assign imm_i = {{20{ins[31]}}, ins[31:20]};
  assign imm_s = {{20{ins[31]}}, ins[31:25], ins[11:7]};
  assign imm_b = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
  assign imm_u = {ins[31:12], 12'b0};
  assign imm_j = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
  // ins[5] separates register ops from immediates; only SRAI among immediates uses bit 30.
  assign alt   = ins[30] & (ins[5] | (ins[14:12] == 3'd5));
  assign alu_r = alu(ins[14:12], alt, rs1v, ins[5] ? rs2v : imm_i);
  assign ld_raw = mem_rdata >> {mem_addr[1:0], 3'b000};

  always_comb begin
    case (ins[13:12])
      2'd0:    store_data = {4{rs2v[7:0]}};
      2'd1:    store_data = {2{rs2v[15:0]}};
      default: store_data = rs2v;
    endcase
  end

  // Register write-back and next-PC selection.
  always_comb begin
    next_pc = pc + 32'd4;
    rd_we   = 1'b0;
    rd_idx  = ins[11:7];
    rd_val  = alu_r;
    if (state == S_WB) begin
      rd_we  = 1'b1;
      rd_idx = ld_rd;
      case (ld_f3)
        3'd0:    rd_val = {{24{ld_raw[7]}}, ld_raw[7:0]};
        3'd1:    rd_val = {{16{ld_raw[15]}}, ld_raw[15:0]};
        3'd4:    rd_val = {24'b0, ld_raw[7:0]};
        3'd5:    rd_val = {16'b0, ld_raw[15:0]};
        default: rd_val = ld_raw;
      endcase
    end else if (state == S_EXEC) begin
      case (ins[6:0])
        OPC_LUI:   begin rd_we = 1'b1; rd_val = imm_u; end
        OPC_AUIPC: begin rd_we = 1'b1; rd_val = pc + imm_u; end
        OPC_JAL:   begin rd_we = 1'b1; rd_val = pc + 32'd4; next_pc = pc + imm_j; end
        OPC_JALR:  begin
          rd_we   = 1'b1;
          rd_val  = pc + 32'd4;
          next_pc = (rs1v + imm_i) & ~32'd1;
        end
        OPC_BRANCH: if (branch_taken(ins[14:12], rs1v, rs2v)) next_pc = pc + imm_b;
        OPC_OPIMM, OPC_OP: rd_we = 1'b1;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && rd_we && rd_idx != 5'd0) rf[rd_idx] <= rd_val;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_FETCH;
      pc         <= 32'h0000_0000;
      ld_pending <= 1'b0;
      ld_f3      <= 3'd0;
      ld_rd      <= 5'd0;
      mem_addr   <= 32'd0;
      mem_we     <= 1'b0;
      mem_be     <= 4'd0;
      mem_wdata  <= 32'd0;
    end else begin
      case (state)
        S_FETCH: state <= S_EXEC;
        S_EXEC: begin
          pc         <= next_pc;
          state      <= S_FETCH;
          ld_pending <= 1'b0;
          if (ins[6:0] == OPC_LOAD) begin
            mem_addr   <= rs1v + imm_i;
            ld_pending <= 1'b1;
            ld_f3      <= ins[14:12];
            ld_rd      <= ins[11:7];
            state      <= S_MEM;
          end else if (ins[6:0] == OPC_STORE) begin
            mem_addr  <= rs1v + imm_s;
            mem_we    <= 1'b1;
            mem_be    <= lane_mask({1'b0, ins[13:12]}, 2'(rs1v[1:0] + imm_s[1:0]));
            mem_wdata <= store_data;
            state     <= S_MEM;
          end
        end
        S_MEM: begin
          mem_we <= 1'b0;
          state  <= ld_pending ? S_WB : S_FETCH;
        end
        default: state <= S_FETCH;
      endcase
    end
  end

endmodule

// File: rtl/dmem.sv
// Data RAM stored as four byte-lane arrays with a single core port.
module dmem
  import apple_riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = DMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic [ADDR_WIDTH-3:0] idx,
  input  logic                  we,
  input  logic [3:0]            be,
  input  logic [31:0]           wdata,
  output logic [31:0]           rdata
);

  localparam int unsigned DEPTH = 1 << (ADDR_WIDTH - 2);

  logic [7:0] ram_symbol0 [0:DEPTH-1];
  logic [7:0] ram_symbol1 [0:DEPTH-1];
  logic [7:0] ram_symbol2 [0:DEPTH-1];
  logic [7:0] ram_symbol3 [0:DEPTH-1];

  always_ff @(posedge clk) begin
    if (we && be[0]) ram_symbol0[idx] <= wdata[7:0];
    if (we && be[1]) ram_symbol1[idx] <= wdata[15:8];
    if (we && be[2]) ram_symbol2[idx] <= wdata[23:16];
    if (we && be[3]) ram_symbol3[idx] <= wdata[31:24];
    rdata <= {ram_symbol3[idx], ram_symbol2[idx], ram_symbol1[idx], ram_symbol0[idx]};
  end

endmodule

// File: rtl/imem.sv
// Dual-port instruction RAM: read-only fetch port plus byte-writable debug port.
module imem
  import apple_riscv_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = IMEM_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [ADDR_WIDTH-3:0] fetch_idx,
  output logic [31:0]           fetch_data,
  input  logic                  dbg_rd,
  input  logic [ADDR_WIDTH-3:0] dbg_rd_idx,
  input  logic                  dbg_wr,
  input  logic [ADDR_WIDTH-3:0] dbg_wr_idx,
  input  logic [3:0]            dbg_be,
  input  logic [31:0]           dbg_wdata,
  output logic [31:0]           dbg_rdata
);

  localparam int unsigned DEPTH = 1 << (ADDR_WIDTH - 2);

  logic [31:0] ram [0:DEPTH-1];
  logic [31:0] merged;

  always_comb begin
    merged = ram[dbg_wr_idx];
    for (int j = 0; j < 4; j++) if (dbg_be[j]) merged[8*j +: 8] = dbg_wdata[8*j +: 8];
  end

  always_ff @(posedge clk) begin
    fetch_data <= ram[fetch_idx];
    if (dbg_wr) ram[dbg_wr_idx] <= merged;
  end

  // A debug read landing on the word being written sees the new data.
  always_ff @(posedge clk) begin
    if (reset) dbg_rdata <= 32'd0;
    else if (dbg_rd) dbg_rdata <= (dbg_wr && dbg_wr_idx == dbg_rd_idx) ? merged : ram[dbg_rd_idx];
  end

endmodule

// File: rtl/apple_riscv_soc.sv
// SoC wrapper: RV32I core, instruction and data RAMs, AHB-Lite debug access to imem.
module apple_riscv_soc
  import apple_riscv_pkg::*;
#(
  parameter int unsigned INSTR_RAM_ADDR_WIDTH = IMEM_ADDR_WIDTH,
  parameter int unsigned DATA_RAM_ADDR_WIDTH  = DMEM_ADDR_WIDTH
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] imem_dbg_ahb_HADDR,
  input  logic        imem_dbg_ahb_HSEL,
  input  logic        imem_dbg_ahb_HREADY,
  input  logic        imem_dbg_ahb_HWRITE,
  input  logic [2:0]  imem_dbg_ahb_HSIZE,
  input  logic [2:0]  imem_dbg_ahb_HBURST,
  input  logic [3:0]  imem_dbg_ahb_HPROT,
  input  logic [1:0]  imem_dbg_ahb_HTRANS,
  input  logic        imem_dbg_ahb_HMASTLOCK,
  input  logic [31:0] imem_dbg_ahb_HWDATA,
  output logic [31:0] imem_dbg_ahb_HRDATA,
  output logic        imem_dbg_ahb_HREADYOUT,
  output logic        imem_dbg_ahb_HRESP
);

  localparam int unsigned IW = INSTR_RAM_ADDR_WIDTH;
  localparam int unsigned DW = DATA_RAM_ADDR_WIDTH;

  logic [31:0]   fetch_addr, fetch_data, mem_addr, mem_wdata, mem_rdata, dmem_rdata, dbg_wdata;
  logic [3:0]    mem_be, dbg_be;
  logic          mem_we, dsel, dsel_q, dbg_rd, dbg_wr, unused_bits;
  logic [IW-3:0] dbg_rd_idx, dbg_wr_idx;

  assign imem_dbg_ahb_HREADYOUT = 1'b1;
  assign imem_dbg_ahb_HRESP     = 1'b0;
  assign unused_bits = ^{fetch_addr[31:IW], fetch_addr[1:0], mem_addr[1:0],
                         imem_dbg_ahb_HBURST, imem_dbg_ahb_HPROT, imem_dbg_ahb_HMASTLOCK};

  apple_riscv core_inst (
    .clk(clk), .reset(reset),
    .fetch_addr(fetch_addr), .fetch_data(fetch_data),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_be(mem_be),
    .mem_wdata(mem_wdata), .mem_rdata(mem_rdata)
  );

  // Only the dmem window is backed; other addresses read zero and drop writes.
  assign dsel      = (mem_addr - DMEM_BASE) < DMEM_SIZE;
  assign mem_rdata = dsel_q ? dmem_rdata : 32'd0;

  always_ff @(posedge clk) begin
    if (reset) dsel_q <= 1'b0;
    else dsel_q <= dsel;
  end

  ahb_imem_dbg_if #(.ADDR_WIDTH(IW)) dbg_if_inst (
    .clk(clk), .reset(reset),
    .haddr(imem_dbg_ahb_HADDR), .hsel(imem_dbg_ahb_HSEL), .hready(imem_dbg_ahb_HREADY),
    .hwrite(imem_dbg_ahb_HWRITE), .hsize(imem_dbg_ahb_HSIZE), .htrans(imem_dbg_ahb_HTRANS),
    .hwdata(imem_dbg_ahb_HWDATA),
    .rd_c(dbg_rd), .rd_idx_c(dbg_rd_idx), .wr_c(dbg_wr), .wr_idx(dbg_wr_idx),
    .wr_be(dbg_be), .wdata_c(dbg_wdata)
  );

  imem #(.ADDR_WIDTH(IW)) imem_inst (
    .clk(clk), .reset(reset),
    .fetch_idx(fetch_addr[IW-1:2]), .fetch_data(fetch_data),
    .dbg_rd(dbg_rd), .dbg_rd_idx(dbg_rd_idx), .dbg_wr(dbg_wr), .dbg_wr_idx(dbg_wr_idx),
    .dbg_be(dbg_be), .dbg_wdata(dbg_wdata), .dbg_rdata(imem_dbg_ahb_HRDATA)
  );

  dmem #(.ADDR_WIDTH(DW)) dmem_inst (
    .clk(clk), .idx(mem_addr[DW-1:2]), .we(mem_we & dsel), .be(mem_be),
    .wdata(mem_wdata), .rdata(dmem_rdata)
  );

endmodule

// File: tb/tb_apple_riscv_soc.sv
// Bench for apple_riscv_soc: AHB debug-port model checked every cycle, plus directed core programs.
module tb_apple_riscv_soc;
  import apple_riscv_pkg::*;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] HADDR;
  logic        HSEL, HREADY, HWRITE, HMASTLOCK;
  logic [2:0]  HSIZE, HBURST;
  logic [3:0]  HPROT;
  logic [1:0]  HTRANS;
  logic [31:0] HWDATA, HRDATA;
  logic        HREADYOUT, HRESP;

  always #5 clk = ~clk;

  apple_riscv_soc dut (
    .clk(clk), .reset(reset),
    .imem_dbg_ahb_HADDR(HADDR), .imem_dbg_ahb_HSEL(HSEL), .imem_dbg_ahb_HREADY(HREADY),
    .imem_dbg_ahb_HWRITE(HWRITE), .imem_dbg_ahb_HSIZE(HSIZE), .imem_dbg_ahb_HBURST(HBURST),
    .imem_dbg_ahb_HPROT(HPROT), .imem_dbg_ahb_HTRANS(HTRANS),
    .imem_dbg_ahb_HMASTLOCK(HMASTLOCK), .imem_dbg_ahb_HWDATA(HWDATA),
    .imem_dbg_ahb_HRDATA(HRDATA), .imem_dbg_ahb_HREADYOUT(HREADYOUT),
    .imem_dbg_ahb_HRESP(HRESP)
  );

  int          checks = 0;
  int          passed = 0;
  logic [31:0] mdl [0:1023];
  logic [31:0] exp_rdata = 32'd0;
  logic        pend = 1'b0;
  logic [9:0]  p_idx = 10'd0;
  logic [3:0]  p_mask = 4'd0;
  logic [31:0] rd_word, saved;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %h, want %h", name, act, exp);
  endtask

  // Lanes covered: an aligned run of 2**size bytes containing the address.
  function automatic logic [3:0] span(input logic [2:0] size, input logic [1:0] a);
    int n = 1 << size;
    int first = int'(a) / n * n;
    logic [3:0] m = 4'd0;
    for (int k = 0; k < 4; k++) if (k >= first && k < first + n) m[k] = 1'b1;
    return m;
  endfunction

  // Transaction-level model of the debug port.
  always @(posedge clk) begin
    if (reset) begin
      pend = 1'b0;
      exp_rdata = 32'd0;
    end else begin
      if (pend)
        for (int j = 0; j < 4; j++) if (p_mask[j]) mdl[p_idx][8*j +: 8] = HWDATA[8*j +: 8];
      if (HSEL && HREADY && HTRANS[1]) begin
        if (HWRITE) begin
          pend = 1'b1;
          p_idx = HADDR[11:2];
          p_mask = span(HSIZE, HADDR[1:0]);
        end else begin
          pend = 1'b0;
          exp_rdata = mdl[HADDR[11:2]];
        end
      end else pend = 1'b0;
    end
  end

  always @(negedge clk) begin
    check("hreadyout", {31'd0, HREADYOUT}, 32'd1);
    check("hresp", {31'd0, HRESP}, 32'd0);
    check("hrdata_model", HRDATA, exp_rdata);
  end

  task automatic ahb_addr(input logic [15:0] a, input logic w, input logic [2:0] sz);
    HSEL = 1'b1; HTRANS = HTRANS_NONSEQ; HWRITE = w; HADDR = a; HSIZE = sz;
  endtask

  task automatic ahb_idle();
    HSEL = 1'b0; HTRANS = HTRANS_IDLE; HWRITE = 1'b0;
  endtask

  task automatic ahb_write(input logic [15:0] a, input logic [2:0] sz, input logic [31:0] d);
    ahb_addr(a, 1'b1, sz);
    @(negedge clk);
    ahb_idle();
    HWDATA = d;
    @(negedge clk);
  endtask

  task automatic ahb_read(input logic [15:0] a, output logic [31:0] d);
    ahb_addr(a, 1'b0, HSIZE_WORD);
    @(negedge clk);
    ahb_idle();
    d = HRDATA;
  endtask

  task automatic load_prog(input logic [31:0] p [0:7], input int n);
    for (int i = 0; i < 1024; i++) begin
      dut.imem_inst.ram[i] = (i < n) ? p[i] : 32'h0000_0013;
      mdl[i] = dut.imem_inst.ram[i];
      dut.dmem_inst.ram_symbol0[i] = 8'h00;
      dut.dmem_inst.ram_symbol1[i] = 8'h00;
      dut.dmem_inst.ram_symbol2[i] = 8'h00;
      dut.dmem_inst.ram_symbol3[i] = 8'h00;
    end
  endtask

  logic [31:0] prog [0:7];

  initial begin
    reset = 1'b1; HADDR = 16'd0; HSEL = 1'b0; HREADY = 1'b1; HWRITE = 1'b0;
    HSIZE = HSIZE_WORD; HBURST = 3'd0; HPROT = 4'd0; HTRANS = HTRANS_IDLE;
    HMASTLOCK = 1'b0; HWDATA = 32'd0;
    prog = '{32'h00500093, 32'h00102023, 32'h13, 32'h13, 32'h13, 32'h13, 32'h13, 32'h13};
    load_prog(prog, 2);
    repeat (3) @(negedge clk);
    check("hrdata_reset", HRDATA, 32'd0);
    reset = 1'b0;
    repeat (20) @(negedge clk);
    check("prog1_sym0", {24'd0, dut.dmem_inst.ram_symbol0[0]}, 32'h05);
    check("prog1_sym1", {24'd0, dut.dmem_inst.ram_symbol1[0]}, 32'h00);
    check("prog1_sym2", {24'd0, dut.dmem_inst.ram_symbol2[0]}, 32'h00);
    check("prog1_sym3", {24'd0, dut.dmem_inst.ram_symbol3[0]}, 32'h00);

    ahb_write(16'h0010, HSIZE_WORD, 32'hDEADBEEF);
    ahb_read(16'h0010, rd_word);
    check("word_rd", rd_word, 32'hDEADBEEF);
    check("word_ram4", dut.imem_inst.ram[4], 32'hDEADBEEF);

    ahb_write(16'h0010, HSIZE_WORD, 32'h11223344);
    ahb_write(16'h0012, HSIZE_BYTE, 32'h00AA0000);
    ahb_read(16'h0010, rd_word);
    check("byte_rd", rd_word, 32'h11AA3344);
    ahb_write(16'h0016, HSIZE_HALF, 32'hBEEF0000);
    ahb_read(16'h0014, rd_word);
    check("half_rd", rd_word, 32'hBEEF0013);

    // Write then read of the same word in consecutive cycles.
    ahb_addr(16'h0020, 1'b1, HSIZE_WORD);
    @(negedge clk);
    HWDATA = 32'h5A5A1234;
    ahb_addr(16'h0020, 1'b0, HSIZE_WORD);
    @(negedge clk);
    ahb_idle();
    check("b2b_rd", HRDATA, 32'h5A5A1234);
    ahb_read(16'h1020, rd_word);
    check("alias_rd", rd_word, 32'h5A5A1234);

    HSEL = 1'b1; HWRITE = 1'b1; HTRANS = HTRANS_IDLE; HADDR = 16'h0010; HWDATA = 32'hFFFFFFFF;
    repeat (4) @(negedge clk);
    ahb_idle();
    @(negedge clk);
    check("idle_ram4", dut.imem_inst.ram[4], 32'h11AA3344);
    check("hrdata_held", HRDATA, 32'h5A5A1234);

    saved = dut.imem_inst.ram[8];
    ahb_addr(16'h0020, 1'b1, HSIZE_WORD);
    @(negedge clk);
    HWDATA = 32'hCAFEF00D;
    reset = 1'b1;
    ahb_idle();
    @(negedge clk);
    @(negedge clk);
    check("rst_ram8", dut.imem_inst.ram[8], 32'h5A5A1234);
    check("rst_ram8_saved", dut.imem_inst.ram[8], saved);
    check("rst_hrdata", HRDATA, 32'd0);

    // sb, out-of-window store and load, then read-back through lw.
    prog = '{32'h07F00113, 32'h000012B7, 32'h002001A3, 32'h0022A023,
             32'h00002183, 32'h00302223, 32'h0002A203, 32'h00402423};
    load_prog(prog, 8);
    dut.dmem_inst.ram_symbol0[2] = 8'hFF;
    dut.dmem_inst.ram_symbol3[2] = 8'hFF;
    @(negedge clk);
    reset = 1'b0;
    repeat (40) @(negedge clk);
    check("sb_sym3", {24'd0, dut.dmem_inst.ram_symbol3[0]}, 32'h7F);
    check("sb_sym0", {24'd0, dut.dmem_inst.ram_symbol0[0]}, 32'h00);
    check("sb_sym1", {24'd0, dut.dmem_inst.ram_symbol1[0]}, 32'h00);
    check("sb_sym2", {24'd0, dut.dmem_inst.ram_symbol2[0]}, 32'h00);
    check("lw_word1", {dut.dmem_inst.ram_symbol3[1], dut.dmem_inst.ram_symbol2[1],
                       dut.dmem_inst.ram_symbol1[1], dut.dmem_inst.ram_symbol0[1]}, 32'h7F000000);
    check("oob_load", {dut.dmem_inst.ram_symbol3[2], dut.dmem_inst.ram_symbol2[2],
                       dut.dmem_inst.ram_symbol1[2], dut.dmem_inst.ram_symbol0[2]}, 32'h00000000);

    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end

endmodule
